// File: rtl/pipe_add_pkg.sv
// Shared constants and the parameter legality check for the pipelined adder.
package pipe_add_pkg;
    localparam int WIDTH_DEF  = 16;
    localparam int STAGES_DEF = 4;

    function automatic bit widths_ok(int width, int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction
endpackage

// File: rtl/add_chunk.sv
// W-bit ripple-carry chunk built from full_add cells; also exposes the carry into its MSB.
module add_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cmsb
);
    // Per-bit scalar carries keep the ripple free of self-referencing vectors.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic cin_b, cout_b;
        if (i == 0) begin : g_first
            assign cin_b = ci;
        end else begin : g_next
            assign cin_b = g_bit[i-1].cout_b;
        end
        full_add u_fa (.a(a[i]), .b(b[i]), .ci(cin_b), .s(s[i]), .co(cout_b));
    end

    assign co   = g_bit[W-1].cout_b;
    assign cmsb = g_bit[W-1].cin_b;
endmodule

// File: rtl/full_add.sv
// One-bit full adder cell.
module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipe_add.sv
// Pipelined ripple-carry adder: one C-bit chunk per stage, carry handed stage to stage,
// valid/ready flow control with a combinational stall chain.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int WIDTH_P  = WIDTH_DEF,
    parameter int STAGES_P = STAGES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] a_i,
    input  logic [WIDTH_P-1:0] b_i,
    input  logic               c_i,
    input  logic               signed_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] sum_o,
    output logic               c_o,
    output logic               ovf_o
);
    localparam int C = (STAGES_P >= 1) ? WIDTH_P / STAGES_P : 1;

    if (!widths_ok(WIDTH_P, STAGES_P)) begin : g_bad_params
        $error("pipe_add: WIDTH_P must be a positive multiple of STAGES_P");
    end

    logic [STAGES_P:1]   vld_pipe;
    logic [STAGES_P-1:0] en;

    // en_k = ~v_k | en_{k+1} unrolled: a stage may load unless it and everything after it is full and stalled.
    for (genvar k = 0; k < STAGES_P; k++) begin : g_en
        assign en[k] = ready_i | ~(&vld_pipe[STAGES_P:k+1]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            if (en[0]) vld_pipe[1] <= valid_i;
            for (int k = 1; k < STAGES_P; k++)
                if (en[k]) vld_pipe[k+1] <= vld_pipe[k];
        end
    end

    for (genvar k = 0; k < STAGES_P; k++) begin : stg
        localparam int RW = WIDTH_P - k * C;

        logic [RW-1:0]      a_in, b_in;
        logic               cin, sgn_in;
        logic [C-1:0]       s;
        logic               co, cm;
        logic [(k+1)*C-1:0] sum_q;
        logic               co_q, sgn_q;

        add_chunk #(.W(C)) u_chunk (
            .a(a_in[C-1:0]), .b(b_in[C-1:0]), .ci(cin), .s(s), .co(co), .cmsb(cm)
        );

        if (k == 0) begin : g_src
            assign a_in   = a_i;
            assign b_in   = b_i;
            assign cin    = c_i;
            assign sgn_in = signed_i;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)    sum_q <= '0;
                else if (en[k]) sum_q <= s;
            end
        end else begin : g_src
            assign a_in   = stg[k-1].g_ops.a_q;
            assign b_in   = stg[k-1].g_ops.b_q;
            assign cin    = stg[k-1].co_q;
            assign sgn_in = stg[k-1].sgn_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)    sum_q <= '0;
                else if (en[k]) sum_q <= {s, stg[k-1].sum_q};
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                co_q  <= 1'b0;
                sgn_q <= 1'b0;
            end else if (en[k]) begin
                co_q  <= co;
                sgn_q <= sgn_in;
            end
        end

        // Operand bits still waiting for a later chunk.
        if (k < STAGES_P - 1) begin : g_ops
            logic [RW-C-1:0] a_q, b_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en[k]) begin
                    a_q <= a_in[RW-1:C];
                    b_q <= b_in[RW-1:C];
                end
            end
        end else begin : g_last
            logic cm_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)    cm_q <= 1'b0;
                else if (en[k]) cm_q <= cm;
            end
        end
    end

    assign ready_o = en[0];
    assign valid_o = vld_pipe[STAGES_P];
    assign sum_o   = stg[STAGES_P-1].sum_q;
    assign c_o     = stg[STAGES_P-1].co_q;
    assign ovf_o   = stg[STAGES_P-1].sgn_q ? (stg[STAGES_P-1].g_last.cm_q ^ stg[STAGES_P-1].co_q)
                                           : stg[STAGES_P-1].co_q;
endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add: 16-bit/4-stage main instance plus an 8-bit/1-stage instance.
module tb_pipe_add;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid_i, ready_o, c_i, signed_i, valid_o, ready_i, c_o, ovf_o;
    logic [15:0] a_i, b_i, sum_o;
    logic        v1_i, r1_o, c1_i, s1_i, v1_o, r1_i, c1_o, ovf1;
    logic [7:0]  a1, b1, sum1;

    pipe_add #(.WIDTH_P(16), .STAGES_P(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .signed_i(signed_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .c_o(c_o), .ovf_o(ovf_o)
    );

    pipe_add #(.WIDTH_P(8), .STAGES_P(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v1_i), .ready_o(r1_o),
        .a_i(a1), .b_i(b1), .c_i(c1_i), .signed_i(s1_i),
        .valid_o(v1_o), .ready_i(r1_i), .sum_o(sum1), .c_o(c1_o), .ovf_o(ovf1)
    );

    int          tests = 0, fails = 0;
    int          emitted;
    logic [17:0] q[$];
    bit          hold_v, last_acc, full_seen;
    logic [17:0] hold_val;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {ovf, carry, sum}.
    function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic c, logic s);
        int unsigned u;
        int          sv;
        logic        co, ov;
        u  = a + b + c;
        sv = int'($signed(a)) + int'($signed(b)) + int'(c);
        co = u[16];
        ov = s ? (sv > 32767 || sv < -32768) : co;
        return {ov, co, u[15:0]};
    endfunction

    // Called at a negedge with inputs set; scores the coming edge and returns at the next negedge.
    task automatic tick();
        logic emt;
        #1;
        if (hold_v) chk("hold_stable", {ovf_o, c_o, sum_o}, hold_val);
        last_acc = valid_i & ready_o;
        emt      = valid_o & ready_i;
        if (emt) begin
            if (q.size() == 0) chk("spurious_out", valid_o, 0);
            else begin
                chk("result", {ovf_o, c_o, sum_o}, q.pop_front());
                emitted++;
            end
        end
        if (last_acc) q.push_back(model(a_i, b_i, c_i, signed_i));
        hold_v   = valid_o & ~ready_i;
        hold_val = {ovf_o, c_o, sum_o};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dir16(string tag, logic [15:0] a, logic [15:0] b, logic c, logic s,
                         logic [15:0] es, logic ec, logic eo);
        a_i = a; b_i = b; c_i = c; signed_i = s; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int n = 1; n < 4; n++) begin
            chk({tag, "_early"}, valid_o, 0);
            tick();
        end
        chk({tag, "_valid"}, valid_o, 1);
        chk({tag, "_sum"}, sum_o, es);
        chk({tag, "_c"}, c_o, ec);
        chk({tag, "_ovf"}, ovf_o, eo);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; valid_i = 0; ready_i = 0; a_i = 0; b_i = 0; c_i = 0; signed_i = 0;
        v1_i = 0; r1_i = 0; a1 = 0; b1 = 0; c1_i = 0; s1_i = 0;
        hold_v = 0; last_acc = 0; emitted = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_sum", sum_o, 16'h0000);
        chk("rst_c", c_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst1_valid", v1_o, 0);
        chk("rst1_ready", r1_o, 1);
        @(negedge clk);
        rst_n = 1'b1;

        dir16("uwrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 1);
        dir16("sovf",  16'h7FFF, 16'h0001, 0, 1, 16'h8000, 0, 1);
        dir16("sneg",  16'hFFFF, 16'hFFFF, 0, 1, 16'hFFFE, 1, 0);
        dir16("xcarry", 16'h00FF, 16'h0000, 1, 0, 16'h0100, 0, 0);

        // Backpressure: six back-to-back adds, downstream stalled for cycles 2..7.
        begin
            int sent = 0;
            emitted = 0; full_seen = 0;
            for (int cyc = 1; cyc <= 40 && !(sent == 6 && q.size() == 0); cyc++) begin
                ready_i  = !(cyc >= 2 && cyc <= 7);
                valid_i  = (sent < 6);
                a_i      = 16'(sent); b_i = 16'h1000; c_i = 0; signed_i = 0;
                #1;
                if (!ready_i && q.size() == 4) begin
                    chk("bp_ready_low", ready_o, 0);
                    full_seen = 1;
                end else if (q.size() < 4) chk("bp_ready_high", ready_o, 1);
                tick();
                if (last_acc) sent++;
            end
            valid_i = 0;
            chk("bp_full_seen", full_seen, 1);
            chk("bp_count", emitted, 6);
            chk("bp_drained", q.size(), 0);
        end

        // Reset in the middle of flight.
        ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1; a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
            tick();
        end
        valid_i = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_sum", sum_o, 16'h0000);
        chk("mid_rst_c", c_o, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        #1 rst_n = 1'b1;
        q.delete(); hold_v = 0;
        @(negedge clk);
        ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_ghost", valid_o, 0);
        end

        // Random traffic with random backpressure; held operands stay put until accepted.
        last_acc = 1; emitted = 0;
        for (int i = 0; i < 400; i++) begin
            if (!valid_i || last_acc) begin
                valid_i = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: a_i = 16'h7FFF;
                    1: a_i = 16'hFFFF;
                    default: a_i = 16'($urandom);
                endcase
                b_i = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
                c_i = 1'($urandom); signed_i = 1'($urandom);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_i = 0; ready_i = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("rand_drained", q.size(), 0);
        chk("rand_some_out", emitted > 50, 1);

        // Single-stage 8-bit instance.
        a1 = 8'h80; b1 = 8'h80; c1_i = 0; s1_i = 1; v1_i = 1; r1_i = 1;
        #1 chk("s1_ready", r1_o, 1);
        @(posedge clk); @(negedge clk);
        chk("s1_valid", v1_o, 1);
        chk("s1_sum", sum1, 8'h00);
        chk("s1_c", c1_o, 1);
        chk("s1_ovf", ovf1, 1);
        a1 = 8'h7F; b1 = 8'h01; s1_i = 0; r1_i = 0;
        #1 chk("s1_stall_ready", r1_o, 0);
        @(posedge clk); @(negedge clk);
        chk("s1_stall_sum", sum1, 8'h00);
        r1_i = 1;
        #1 chk("s1_release_ready", r1_o, 1);
        @(posedge clk); @(negedge clk);
        v1_i = 0;
        chk("s1_u_sum", sum1, 8'h80);
        chk("s1_u_ovf", ovf1, 0);
        @(posedge clk); @(negedge clk);
        chk("s1_empty", v1_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
